// File: rtl/vector_reg_bank.sv
// Vector register file with per-lane masked writes, pending scoreboard and bulk clear FSM (option: VREG_BYPASS_EN).
// Latency: reads combinational, writes/reservations take effect at the next edge; bulk clear runs NREGS cycles.
// Backpressure: rsv_ready drops while a register is pending or a clear runs; writes are dropped during clear.
module vector_reg_bank #(
  parameter int NREGS  = 8,
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  localparam int AW    = $clog2(NREGS),
  localparam int VW    = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic [VW-1:0]     ro1,
  output logic [VW-1:0]     ro2,
  input  logic              write_enable,
  input  logic [AW-1:0]     rd,
  input  logic [LANES-1:0]  write_mask,
  input  logic [VW-1:0]     write_data,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_rd,
  output logic              rsv_ready,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [VW-1:0]    rf [NREGS];
  logic [NREGS-1:0] pending;

  logic idle;
  logic clr_start;
  logic do_wr;
  logic do_rsv;

  assign idle      = (state_q == IDLE);
  assign clr_start = idle && clr_req;
  // clr_req in the same cycle swallows any write or reservation
  assign do_wr     = idle && !clr_req && write_enable;
  assign do_rsv    = idle && !clr_req && rsv_valid && rsv_ready;
  assign rsv_ready = idle && !pending[rsv_rd];
  assign clr_busy  = !idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // counter wraps back to 0 as the last register is zeroed
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (state_q == CLEAR) begin
      rf[cnt_q] <= '0;
    end else if (do_wr) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_mask[l]) rf[rd][l*LANE_W +: LANE_W] <= write_data[l*LANE_W +: LANE_W];
      end
    end
  end

  // reservation is applied after the write-clear so a same-edge set wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (clr_start) begin
      pending <= '0;
    end else begin
      if (do_wr)  pending[rd]     <= 1'b0;
      if (do_rsv) pending[rsv_rd] <= 1'b1;
    end
  end

`ifdef VREG_BYPASS_EN
  logic byp1, byp2;

  assign byp1 = idle && write_enable && (rs1 == rd);
  assign byp2 = idle && write_enable && (rs2 == rd);

  always_comb begin
    ro1 = rf[rs1];
    ro2 = rf[rs2];
    for (int l = 0; l < LANES; l++) begin
      if (byp1 && write_mask[l]) ro1[l*LANE_W +: LANE_W] = write_data[l*LANE_W +: LANE_W];
      if (byp2 && write_mask[l]) ro2[l*LANE_W +: LANE_W] = write_data[l*LANE_W +: LANE_W];
    end
  end

  assign busy1 = pending[rs1] && !byp1;
  assign busy2 = pending[rs2] && !byp2;
`else
  assign ro1   = rf[rs1];
  assign ro2   = rf[rs2];
  assign busy1 = pending[rs1];
  assign busy2 = pending[rs2];
`endif

endmodule

// File: tb/tb_vector_reg_bank.sv
// Self-checking bench for vector_reg_bank: constant vector table, corner sequences, random run against a reference model.
module tb_vector_reg_bank;
  localparam int NREGS  = 8;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int AW     = 3;
  localparam int VW     = 128;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, rd, rsv_rd;
  logic [VW-1:0]   ro1, ro2, write_data;
  logic            write_enable, rsv_valid, rsv_ready, busy1, busy2, clr_req, clr_busy;
  logic [LANES-1:0] write_mask;

  int errors = 0;
  int checks = 0;

  vector_reg_bank #(.NREGS(NREGS), .LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ro1(ro1), .ro2(ro2),
    .write_enable(write_enable), .rd(rd), .write_mask(write_mask), .write_data(write_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
    .busy1(busy1), .busy2(busy2), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: register contents, pending flags, and remaining clear work.
  logic [VW-1:0] m_rf [NREGS];
  bit            m_pend [NREGS];
  bit            m_clearing;
  int            m_next_zero;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_rf[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_clearing = 1'b0;
    m_next_zero = 0;
  endtask

  function automatic logic [VW-1:0] m_ro(input logic [AW-1:0] rs);
    logic [VW-1:0] v;
    v = m_rf[rs];
`ifdef VREG_BYPASS_EN
    if (!m_clearing && write_enable && rs == rd)
      for (int l = 0; l < LANES; l++)
        if (write_mask[l]) v[l*LANE_W +: LANE_W] = write_data[l*LANE_W +: LANE_W];
`endif
    return v;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] rs);
`ifdef VREG_BYPASS_EN
    if (!m_clearing && write_enable && rs == rd) return 1'b0;
`endif
    return m_pend[rs];
  endfunction

  task automatic model_step();
    bit ready;
    if (m_clearing) begin
      m_rf[m_next_zero] = '0;
      m_next_zero = m_next_zero + 1;
      if (m_next_zero == NREGS) begin
        m_clearing = 1'b0;
        m_next_zero = 0;
      end
    end else if (clr_req) begin
      m_clearing = 1'b1;
      m_next_zero = 0;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    end else begin
      ready = !m_pend[rsv_rd];
      if (write_enable) begin
        for (int l = 0; l < LANES; l++)
          if (write_mask[l]) m_rf[rd][l*LANE_W +: LANE_W] = write_data[l*LANE_W +: LANE_W];
        m_pend[rd] = 1'b0;
      end
      if (rsv_valid && ready) m_pend[rsv_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    if (rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " ro1"}, ro1, m_ro(rs1));
    chk({tag, " ro2"}, ro2, m_ro(rs2));
    chk({tag, " busy1"}, {127'd0, busy1}, {127'd0, m_busy(rs1)});
    chk({tag, " busy2"}, {127'd0, busy2}, {127'd0, m_busy(rs2)});
    chk({tag, " rsv_ready"}, {127'd0, rsv_ready}, {127'd0, !m_clearing && !m_pend[rsv_rd]});
    chk({tag, " clr_busy"}, {127'd0, clr_busy}, {127'd0, m_clearing});
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0; rd = '0; write_mask = '0; write_data = '0;
    rsv_valid = 1'b0; rsv_rd = '0; clr_req = 1'b0;
  endtask

  typedef struct {
    logic           we;
    logic [AW-1:0]  rd;
    logic [3:0]     mask;
    logic [VW-1:0]  data;
    logic           rv;
    logic [AW-1:0]  rrd;
    logic           exp_rdy;
    logic [AW-1:0]  rs;
    logic [VW-1:0]  exp_ro;
    logic           exp_busy;
  } vec_t;

  vec_t tbl [10];
  logic [VW-1:0] fill_val;
  logic [VW-1:0] old_val;
  int cnt;

  initial begin
    tbl[0] = '{1'b1, 3'd3, 4'b0101, {32'd44, 32'd33, 32'd22, 32'd11}, 1'b0, 3'd0, 1'b1, 3'd3, {32'd0, 32'd33, 32'd0, 32'd11}, 1'b0};
    tbl[1] = '{1'b1, 3'd3, 4'b1010, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 3'd0, 1'b1, 3'd3, {32'd4, 32'd33, 32'd2, 32'd11}, 1'b0};
    tbl[2] = '{1'b1, 3'd3, 4'b0000, {128{1'b1}}, 1'b0, 3'd0, 1'b1, 3'd3, {32'd4, 32'd33, 32'd2, 32'd11}, 1'b0};
    tbl[3] = '{1'b0, 3'd0, 4'b0000, 128'd0, 1'b1, 3'd5, 1'b1, 3'd5, 128'd0, 1'b1};
    tbl[4] = '{1'b0, 3'd0, 4'b0000, 128'd0, 1'b1, 3'd5, 1'b0, 3'd5, 128'd0, 1'b1};
    tbl[5] = '{1'b1, 3'd5, 4'b1111, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0, 3'd5, 1'b0, 3'd5, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0};
    tbl[6] = '{1'b1, 3'd5, 4'b0000, 128'd0, 1'b1, 3'd5, 1'b1, 3'd5, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b1};
    tbl[7] = '{1'b1, 3'd5, 4'b0000, 128'd0, 1'b0, 3'd5, 1'b0, 3'd5, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0};
    tbl[8] = '{1'b1, 3'd5, 4'b1100, {32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 3'd5, 1'b1, 3'd5, {32'd1, 32'd2, 32'd6, 32'd5}, 1'b1};
    tbl[9] = '{1'b1, 3'd0, 4'b1111, {32'hdead, 32'hbeef, 32'hcafe, 32'hf00d}, 1'b1, 3'd1, 1'b1, 3'd0,
               {32'hdead, 32'hbeef, 32'hcafe, 32'hf00d}, 1'b0};

    rst = 1'b1;
    rs1 = '0; rs2 = '0;
    idle_inputs();
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("reset ro1", ro1, 128'd0);
    chk("reset ro2", ro2, 128'd0);
    chk("reset busy1", {127'd0, busy1}, 128'd0);
    chk("reset clr_busy", {127'd0, clr_busy}, 128'd0);
    chk("reset rsv_ready", {127'd0, rsv_ready}, 128'd1);
    tick();
    tick();
    rst = 1'b1;

    // Constant vector table: apply one cycle, then read back the target register.
    for (int i = 0; i < 10; i++) begin
      write_enable = tbl[i].we; rd = tbl[i].rd; write_mask = tbl[i].mask; write_data = tbl[i].data;
      rsv_valid = tbl[i].rv; rsv_rd = tbl[i].rrd;
      #1;
      chk($sformatf("vec%0d rsv_ready", i), {127'd0, rsv_ready}, {127'd0, tbl[i].exp_rdy});
      tick();
      idle_inputs();
      rs1 = tbl[i].rs;
      #1;
      chk($sformatf("vec%0d ro1", i), ro1, tbl[i].exp_ro);
      chk($sformatf("vec%0d busy1", i), {127'd0, busy1}, {127'd0, tbl[i].exp_busy});
    end

    // Bulk clear with writes, reservations and clr_req ignored while it runs.
    for (int r = 0; r < NREGS; r++) begin
      write_enable = 1'b1; rd = AW'(r); write_mask = 4'hf;
      write_data = {4{32'h1000_0000 + 32'(r)}};
      tick();
    end
    idle_inputs();
    rsv_valid = 1'b1; rsv_rd = 3'd2;
    tick();
    idle_inputs();
    rs1 = 3'd2;
    #1;
    chk("clear pre busy1", {127'd0, busy1}, 128'd1);
    clr_req = 1'b1; write_enable = 1'b1; rd = 3'd4; write_mask = 4'hf; write_data = '1;
    tick();
    chk("clear entry clr_busy", {127'd0, clr_busy}, 128'd1);
    cnt = 0;
    while (clr_busy && cnt < 20) begin
      write_enable = 1'b1; rd = AW'(cnt); write_mask = 4'hf; write_data = '1;
      rsv_valid = 1'b1; rsv_rd = AW'(cnt); clr_req = 1'b1;
      #1;
      chk("clear rsv_ready", {127'd0, rsv_ready}, 128'd0);
      tick();
      cnt++;
    end
    idle_inputs();
    chk("clear duration", 128'(cnt), 128'd8);
    for (int r = 0; r < NREGS; r++) begin
      rs1 = AW'(r); rs2 = AW'(NREGS - 1 - r);
      #1;
      chk($sformatf("post-clear ro1 r%0d", r), ro1, 128'd0);
      chk($sformatf("post-clear busy1 r%0d", r), {127'd0, busy1}, 128'd0);
    end

    // Reset during a clear aborts it immediately, and clocking under reset changes nothing.
    for (int r = 0; r < NREGS; r++) begin
      write_enable = 1'b1; rd = AW'(r); write_mask = 4'hf; write_data = {4{32'h0a0b_0000 + 32'(r)}};
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    rs1 = 3'd7; rs2 = 3'd6;
    #1;
    chk("midclear ro1 before reset", ro1, {4{32'h0a0b_0007}});
    chk("midclear clr_busy", {127'd0, clr_busy}, 128'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("async reset ro1", ro1, 128'd0);
    chk("async reset ro2", ro2, 128'd0);
    chk("async reset busy2", {127'd0, busy2}, 128'd0);
    chk("async reset clr_busy", {127'd0, clr_busy}, 128'd0);
    chk("async reset rsv_ready", {127'd0, rsv_ready}, 128'd1);
    write_enable = 1'b1; rd = 3'd7; write_mask = 4'hf; write_data = '1; clr_req = 1'b1;
    tick(); tick();
    chk("edge under reset ro1", ro1, 128'd0);
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("after release clr_busy", {127'd0, clr_busy}, 128'd0);
    for (int r = 0; r < NREGS; r++) begin
      rs1 = AW'(r);
      #1;
      chk($sformatf("after release ro1 r%0d", r), ro1, 128'd0);
    end

    // Same-cycle read of a register being written.
    old_val = {32'h1111, 32'h2222, 32'h3333, 32'h4444};
    fill_val = {32'h9999, 32'h8888, 32'h7777, 32'h6666};
    write_enable = 1'b1; rd = 3'd2; write_mask = 4'hf; write_data = old_val;
    tick();
    write_data = fill_val; rs1 = 3'd2;
    #1;
`ifdef VREG_BYPASS_EN
    chk("bypass same cycle ro1", ro1, fill_val);
`else
    chk("no-bypass same cycle ro1", ro1, old_val);
`endif
    tick();
    idle_inputs();
    #1;
    chk("write next cycle ro1", ro1, fill_val);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rs1 = AW'($urandom_range(0, NREGS - 1));
      rs2 = AW'($urandom_range(0, NREGS - 1));
      write_enable = 1'($urandom_range(0, 1));
      rd = AW'($urandom_range(0, NREGS - 1));
      write_mask = 4'($urandom_range(0, 15));
      write_data = {$urandom, $urandom, $urandom, $urandom};
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_rd = AW'($urandom_range(0, NREGS - 1));
      clr_req = ($urandom_range(0, 39) == 0);
      #1;
      chk_model($sformatf("rand%0d", n));
      tick();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_reg_bank.md
VECTOR_REG_BANK -- requirements
Module: vector_reg_bank

Interface
REQ-001 Parameters SHALL be, one per line:
  NREGS, 8, number of vector registers (power of two, >=2); AW = clog2(NREGS)
  LANES, 4, lanes per register
  LANE_W, 32, bits per lane; VW = LANES*LANE_W
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-low
  rs1, rs2  in  AW  read addresses
  ro1, ro2  out  VW  read data, lane i = bits [i*LANE_W +: LANE_W]
  write_enable  in  1  write request
  rd  in  AW  write address
  write_mask  in  LANES  per-lane write enable
  write_data  in  VW  write data
  rsv_valid  in  1  reserve destination register (issue)
  rsv_rd  in  AW  register to reserve
  rsv_ready  out  1  reservation accepted this cycle
  busy1, busy2  out  1  pending bit of rs1 / rs2
  clr_req  in  1  start bulk clear
  clr_busy  out  1  bulk clear in progress

Function
REQ-003 ro1/ro2 SHALL be combinational reads of rf[rs1]/rf[rs2]; busy1/busy2 combinational reads of pending[rs1]/pending[rs2].
REQ-004 State machine SHALL have two states: IDLE, CLEAR.
REQ-005 In IDLE, write_enable=1 SHALL update, at the edge, only lanes of rf[rd] whose write_mask bit is 1; other lanes hold.
REQ-006 write_enable=1 with write_mask=0 SHALL change no data but SHALL still clear pending[rd].
REQ-007 rsv_ready SHALL equal (state==IDLE) && !pending[rsv_rd], combinational.
REQ-008 rsv_valid && rsv_ready SHALL set pending[rsv_rd] at the edge.
REQ-009 Same-edge write clearing and reservation setting the same register: set SHALL win (pending ends 1), data still written.
REQ-010 rsv_valid with rsv_ready=0 SHALL have no effect; requester retries.
REQ-011 In IDLE, clr_req=1 SHALL enter CLEAR next edge, zero all pending bits at that edge, load counter to 0.
REQ-012 clr_req takes priority: a write or reservation in the same cycle SHALL be dropped.
REQ-013 In CLEAR, each edge SHALL zero rf[counter] (all lanes) and increment counter; after zeroing NREGS-1 SHALL return to IDLE; total NREGS cycles.
REQ-014 In CLEAR, clr_busy=1, rsv_ready=0; write_enable, rsv_valid, clr_req SHALL be ignored.
REQ-015 Counter SHALL be AW bits and wrap to 0 on exit.

Reset
REQ-016 rst=0 SHALL immediately, independent of clk: all rf lanes 0, pending all 0, state IDLE, counter 0; hence ro1=ro2=0, busy1=busy2=0, clr_busy=0, rsv_ready=1.
REQ-017 rst asserted during CLEAR SHALL abort the clear; first edge after release in IDLE.
REQ-018 Edges while rst=0 SHALL not alter state.

Configuration
REQ-019 Macro VREG_BYPASS_EN: when defined, if write_enable=1 in IDLE and rs1 (rs2)==rd, ro1 (ro2) SHALL return write_data for masked-in lanes and rf for others, same cycle, and busy1/busy2 SHALL read 0 for that register; when undefined, ro/busy reflect only stored state (new data visible the cycle after the write).

Verification
REQ-020 Reset: rst=0 mid-run with rf nonzero -> ro1=ro2=0, busy1=busy2=0, clr_busy=0 without a clock edge.
REQ-021 Masked write: rf[3]=all 0, write rd=3, mask=4'b0101, data lanes {D,C,B,A}={44,33,22,11} -> next cycle rs1=3 reads lanes {0,33,0,11}.
REQ-022 Scoreboard: reserve rsv_rd=5 -> busy1=1 for rs1=5, rsv_ready=0 for rsv_rd=5; write rd=5 -> busy1=0 next cycle; same-edge write rd=5 + reserve 5 (when free) -> pending[5]=1.
REQ-023 Clear: fill all 8 regs, reserve 2, pulse clr_req -> clr_busy high exactly 8 cycles, writes during it ignored, afterwards all regs 0, busy all 0.
REQ-024 Reset mid-clear: rst=0 at clear cycle 3 -> IDLE, clr_busy=0, all regs 0 after release.
REQ-025 Bypass: write rd=rs1=2, mask all ones, data X -> with VREG_BYPASS_EN ro1=X same cycle; without it ro1=old value that cycle, X next cycle.
